// File: rtl/image_buffer.sv
// -----------------------------------------------------------------------------
// image_buffer
//   Byte-addressed storage for one binary OCR image. The controller FSM writes
//   SPI bytes into it; the BNN core reads it back one full row per cycle.
//   The block tracks how many bytes have been accepted and reports
//   full/empty back to the controller. A clear request zeroes the whole
//   memory, one byte per cycle, before new writes are accepted.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   clear         wipe request (acted on at its rising edge only)
//   wr_req        write strobe; wr_data stored at byte address wr_addr
//   wr_ready      writes are being accepted this cycle
//   buffer_full   IMG_BYTES writes accepted since the last wipe
//   buffer_empty  wipe finished and no write accepted yet
//   overflow_err  sticky: a write was dropped (buffer full or bad address)
//   rd_en         row read request for row rd_row_addr
//   rd_valid      rd_row holds the requested row (one cycle after rd_en)
//   rd_row        row pixels, MSB = column 0; zero when rd_valid is low
// -----------------------------------------------------------------------------
module image_buffer #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 7,
    parameter int ROW_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_req,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_ready,
    output logic              buffer_full,
    output logic              buffer_empty,
    output logic              overflow_err,
    input  logic              rd_en,
    input  logic [ROW_AW-1:0] rd_row_addr,
    output logic              rd_valid,
    output logic [IMG_W-1:0]  rd_row
);

    localparam int BPR       = IMG_W / 8;          // bytes per row
    localparam int IMG_BYTES = IMG_W * IMG_H / 8;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(IMG_BYTES - 1);
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(IMG_BYTES - 1);

    typedef enum logic [1:0] {
        S_WIPE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wipe_ptr_reg, wipe_ptr_next;
    logic [ADDR_W:0]   wr_count_reg, wr_count_next;
    logic              empty_reg, empty_next;
    logic              ovf_reg, ovf_next;
    logic              rd_valid_reg, rd_valid_next;
    logic              clear_d_reg;

    logic              clear_rise;
    logic              addr_ok;
    logic              row_ok;

    // Single shared write port into the row banks (wipe or accepted write)
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [31:0]       mem_addr_ext;
    logic [ROW_AW-1:0] mem_row;

    assign clear_rise = clear & ~clear_d_reg;
    assign addr_ok    = {{(32 - ADDR_W){1'b0}}, wr_addr} < IMG_BYTES;
    assign row_ok     = {{(32 - ROW_AW){1'b0}}, rd_row_addr} < IMG_H;

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wipe_ptr_next = wipe_ptr_reg;
        wr_count_next = wr_count_reg;
        empty_next    = empty_reg;
        ovf_next      = ovf_reg;
        mem_we        = 1'b0;
        mem_addr      = wipe_ptr_reg;
        mem_wdata     = 8'h00;
        // Reads are only honoured once the image is complete; a clear in the
        // same cycle cancels the read.
        rd_valid_next = rd_en && (state_reg == S_FULL) && row_ok && !clear_rise;

        case (state_reg)
            S_WIPE: begin
                // clear edges are ignored here: the wipe always runs to the end
                mem_we        = 1'b1;
                wipe_ptr_next = wipe_ptr_reg + ADDR_W'(1);
                if (wipe_ptr_reg == LAST_PTR) begin
                    state_next = S_FILL;
                    empty_next = 1'b1;
                end
            end

            S_FILL: begin
                if (clear_rise) begin
                    // clear wins over a same-cycle write, which is silently dropped
                    state_next    = S_WIPE;
                    wipe_ptr_next = '0;
                    wr_count_next = '0;
                    empty_next    = 1'b0;
                    ovf_next      = 1'b0;
                end else if (wr_req) begin
                    if (addr_ok) begin
                        mem_we        = 1'b1;
                        mem_addr      = wr_addr;
                        mem_wdata     = wr_data;
                        wr_count_next = wr_count_reg + (ADDR_W + 1)'(1);
                        empty_next    = 1'b0;
                        // Counts accepts, not distinct addresses
                        if (wr_count_reg == LAST_CNT) begin
                            state_next = S_FULL;
                        end
                    end else begin
                        ovf_next = 1'b1;
                    end
                end
            end

            S_FULL: begin
                if (clear_rise) begin
                    state_next    = S_WIPE;
                    wipe_ptr_next = '0;
                    wr_count_next = '0;
                    empty_next    = 1'b0;
                    ovf_next      = 1'b0;
                end else if (wr_req) begin
                    ovf_next = 1'b1;
                end
            end

            default: begin
                state_next = S_WIPE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_WIPE;
            wipe_ptr_reg <= '0;
            wr_count_reg <= '0;
            empty_reg    <= 1'b0;
            ovf_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
            clear_d_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wipe_ptr_reg <= wipe_ptr_next;
            wr_count_reg <= wr_count_next;
            empty_reg    <= empty_next;
            ovf_reg      <= ovf_next;
            rd_valid_reg <= rd_valid_next;
            clear_d_reg  <= clear;
        end
    end

    assign wr_ready     = (state_reg == S_FILL);
    assign buffer_full  = (state_reg == S_FULL);
    assign buffer_empty = empty_reg;
    assign overflow_err = ovf_reg;
    assign rd_valid     = rd_valid_reg;

    // ------------------------------------------------------------------
    // Storage: one byte-wide bank per byte column of a row, so a whole row
    // comes out of the banks in parallel. Byte address a lives in bank
    // (a % BPR) at entry (a / BPR). Contents are not reset; the wipe
    // sequence zeroes them.
    // ------------------------------------------------------------------
    assign mem_addr_ext = {{(32 - ADDR_W){1'b0}}, mem_addr};
    assign mem_row      = ROW_AW'(mem_addr_ext / BPR);

    for (genvar gi = 0; gi < BPR; gi++) begin : g_bank
        logic [7:0] bank_mem [IMG_H];
        logic [7:0] bank_q;
        logic       bank_we;

        assign bank_we = mem_we && ((mem_addr_ext % BPR) == gi);

        always_ff @(posedge clk) begin
            if (bank_we) begin
                bank_mem[mem_row] <= mem_wdata;
            end
            bank_q <= bank_mem[rd_row_addr];
        end

        // Lowest byte of the row lands in the MSBs; masked when not valid
        assign rd_row[IMG_W - 1 - 8 * gi -: 8] = rd_valid_reg ? bank_q : 8'h00;
    end

endmodule

// File: tb/tb_image_buffer.sv
// -----------------------------------------------------------------------------
// tb_image_buffer
//   Self-checking bench for image_buffer. Read requests push the expected row
//   into a scoreboard queue; an independent monitor pops and compares each
//   time the DUT raises rd_valid. Flags are compared against a byte-array
//   model of the image. ADDR_W is widened to 8 so out-of-range addresses
//   (>= 128) can be driven.
// -----------------------------------------------------------------------------
module tb_image_buffer;

    localparam int IMG_W     = 32;
    localparam int IMG_H     = 32;
    localparam int ADDR_W    = 8;
    localparam int ROW_AW    = 5;
    localparam int BPR       = IMG_W / 8;
    localparam int IMG_BYTES = IMG_W * IMG_H / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              wr_req = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic              rd_en = 1'b0;
    logic [ROW_AW-1:0] rd_row_addr = '0;
    logic              wr_ready, buffer_full, buffer_empty, overflow_err, rd_valid;
    logic [IMG_W-1:0]  rd_row;

    image_buffer #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .ROW_AW (ROW_AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .wr_addr      (wr_addr),
        .wr_ready     (wr_ready),
        .buffer_full  (buffer_full),
        .buffer_empty (buffer_empty),
        .overflow_err (overflow_err),
        .rd_en        (rd_en),
        .rd_row_addr  (rd_row_addr),
        .rd_valid     (rd_valid),
        .rd_row       (rd_row)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the image as a byte array plus accept count / error flag
    logic [7:0]       ref_mem [IMG_BYTES];
    int               ref_count = 0;
    bit               ref_ovf = 1'b0;
    logic [IMG_W-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [IMG_W-1:0] ref_row(input int r);
        logic [IMG_W-1:0] v;
        v = '0;
        for (int b = 0; b < BPR; b++) begin
            v = (v << 8) | IMG_W'(ref_mem[r * BPR + b]);
        end
        return v;
    endfunction

    task automatic model_wipe();
        for (int i = 0; i < IMG_BYTES; i++) ref_mem[i] = 8'h00;
        ref_count = 0;
        ref_ovf   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every valid row is matched against the oldest request
    always @(negedge clk) begin
        if (rst_n && rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_unexpected: got rd_valid=1 row 0x%h, expected no valid row", rd_row);
            end else begin
                check("rd_row", rd_row, exp_q.pop_front());
            end
        end
    end

    task automatic read_expect(input int row, input logic [IMG_W-1:0] exp);
        rd_en       = 1'b1;
        rd_row_addr = ROW_AW'(row);
        exp_q.push_back(exp);
        step();
        rd_en = 1'b0;
        $display("read  row %0d expect 0x%h", row, exp);
    endtask

    task automatic do_read(input int row);
        if (ref_count == IMG_BYTES) begin
            read_expect(row, ref_row(row));
        end else begin
            rd_en       = 1'b1;
            rd_row_addr = ROW_AW'(row);
            step();
            rd_en = 1'b0;
            check("rd_valid_not_full", rd_valid, 0);
            check("rd_row_not_full", rd_row, 0);
            $display("read  row %0d while not full, expect no data", row);
        end
    endtask

    task automatic do_write(input int addr, input logic [7:0] data);
        wr_req  = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        if (ref_count < IMG_BYTES && addr < IMG_BYTES) begin
            ref_mem[addr] = data;
            ref_count++;
        end else begin
            ref_ovf = 1'b1;
        end
        step();
        wr_req = 1'b0;
        $display("write addr %0d data 0x%h count %0d", addr, data, ref_count);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_full"}, buffer_full, (ref_count == IMG_BYTES));
        check({tag, "_empty"}, buffer_empty, (ref_count == 0));
        check({tag, "_ovf"}, overflow_err, ref_ovf);
        check({tag, "_wr_ready"}, wr_ready, (ref_count < IMG_BYTES));
    endtask

    // Waits (bounded) for buffer_empty; also probes a read mid-wipe
    task automatic wait_wipe(input string tag);
        int cyc;
        cyc = 0;
        while (!buffer_empty && cyc < 300) begin
            rd_en       = (cyc == 5);
            rd_row_addr = 5'd3;
            step();
            rd_en = 1'b0;
            cyc++;
            if (cyc == 6) begin
                check({tag, "_wipe_rd_valid"}, rd_valid, 0);
                check({tag, "_wipe_ready"}, wr_ready, 0);
            end
        end
        check({tag, "_wipe_cycles"}, cyc, IMG_BYTES);
        $display("wipe  %s done after %0d cycles", tag, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int first_empty;
        int drops;
        int guard;
        int rows [IMG_H];
        bit bad_done;

        model_wipe();

        // ---- reset state ----
        step();
        step();
        check("rst_full", buffer_full, 0);
        check("rst_empty", buffer_empty, 0);
        check("rst_ready", wr_ready, 0);
        check("rst_ovf", overflow_err, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_row", rd_row, 0);
        rst_n = 1'b1;

        wait_wipe("init");
        check_flags("after_init");
        do_read(0);

        // ---- sequential fill, data = address ----
        for (int i = 0; i < IMG_BYTES; i++) begin
            do_write(i, 8'(i));
            if (i == 64) do_read(1);
            if (i == IMG_BYTES - 2) check_flags("fill127");
        end
        check_flags("fill128");
        read_expect(0, 32'h00010203);
        read_expect(31, 32'h7C7D7E7F);

        // ---- write while full ----
        do_write(0, 8'hFF);
        check_flags("write_full");
        read_expect(0, 32'h00010203);

        // ---- clear pulse with simultaneous write ----
        clear   = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 8'd5;
        wr_data = 8'hAA;
        step();
        clear  = 1'b0;
        wr_req = 1'b0;
        model_wipe();
        check("clr_full", buffer_full, 0);
        check("clr_empty", buffer_empty, 0);
        check("clr_ovf", overflow_err, 0);
        wait_wipe("clear");
        check_flags("after_clear");

        // ---- refill zeros at random addresses, one bad address mid-way ----
        bad_done = 1'b0;
        guard    = 0;
        while (ref_count < IMG_BYTES && guard < 1000) begin
            guard++;
            if (ref_count == 50 && !bad_done) begin
                do_write(200, 8'h5A);
                bad_done = 1'b1;
                check_flags("bad_addr");
            end else begin
                do_write($urandom_range(0, IMG_BYTES - 1), 8'h00);
            end
            if (ref_count == IMG_BYTES - 1) check_flags("zero127");
        end
        check_flags("zero_full");
        for (int r = 0; r < IMG_H; r++) do_read(r);

        // ---- clear held high for 200 cycles ----
        clear       = 1'b1;
        first_empty = -1;
        drops       = 0;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (buffer_empty && first_empty < 0) first_empty = c;
            if (first_empty >= 0 && !buffer_empty) drops++;
        end
        clear = 1'b0;
        model_wipe();
        check("hold_first_empty", first_empty, 129);
        check("hold_empty_drops", drops, 0);
        step();
        check_flags("hold_release");

        // ---- random fill with random data and occasional bad addresses ----
        guard = 0;
        while (ref_count < IMG_BYTES && guard < 2000) begin
            guard++;
            if ($urandom_range(0, 7) == 0) do_write($urandom_range(IMG_BYTES, 255), 8'($urandom));
            else do_write($urandom_range(0, IMG_BYTES - 1), 8'($urandom));
        end
        check_flags("rand_full");
        for (int r = 0; r < IMG_H; r++) rows[r] = r;
        for (int r = IMG_H - 1; r > 0; r--) begin
            int j;
            int t;
            j       = $urandom_range(0, r);
            t       = rows[r];
            rows[r] = rows[j];
            rows[j] = t;
        end
        for (int r = 0; r < IMG_H; r++) do_read(rows[r]);

        // ---- asynchronous reset in the middle of a fill ----
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_wipe();
        wait_wipe("pre_reset");
        do_write(250, 8'h11);
        for (int i = 1; i < 60; i++) do_write($urandom_range(0, IMG_BYTES - 1), 8'($urandom));
        check_flags("before_reset");
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_full", buffer_full, 0);
        check("mid_rst_empty", buffer_empty, 0);
        check("mid_rst_ready", wr_ready, 0);
        check("mid_rst_ovf", overflow_err, 0);
        check("mid_rst_rd_valid", rd_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_wipe();
        wait_wipe("post_reset");
        for (int i = 0; i < IMG_BYTES; i++) begin
            do_write($urandom_range(0, IMG_BYTES - 1), 8'($urandom));
            if (i == IMG_BYTES - 2) check_flags("reset_fill127");
        end
        check_flags("reset_fill128");
        for (int r = 0; r < 8; r++) do_read($urandom_range(0, IMG_H - 1));

        step();
        #5;
        check("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
